// File: rtl/branch_redirect_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_redirect_unit_pkg
//
// Purpose : Shared types and helpers for the commit-side branch redirect logic.
//           - redirect_state_t : FSM state encoding (IDLE, PENDING, REDIRECT)
//           - to_writeback_t   : branch-unit writeback bundle, used when the
//                                wb_* fields are carried as one struct
//           - rob_age()        : distance of a ROB index from the ROB head
// Ports   : none (package)
// -----------------------------------------------------------------------------
package branch_redirect_unit_pkg;

   // Default geometry of the core.
   localparam int ROB_IDX_W_DEF = 4;
   localparam int XLEN_DEF      = 32;

   // Widest ROB index that rob_age() handles.
   localparam int ROB_AGE_MAX_W = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PENDING  = 2'd1,
      REDIRECT = 2'd2
   } redirect_state_t;

   typedef struct packed {
      logic                     valid;
      logic                     br_en;
      logic [ROB_IDX_W_DEF-1:0] rob_idx;
      logic [XLEN_DEF-1:0]      pc_new;
   } to_writeback_t;

   // Age of a ROB entry relative to the current head. The subtraction wraps
   // modulo 2^idx_w on purpose: the entry at the head has age 0 and the
   // smaller the age, the older the instruction. Indices are passed
   // zero-extended to ROB_AGE_MAX_W bits so one function serves any ROB size.
   function automatic logic [ROB_AGE_MAX_W-1:0] rob_age(
      input logic [ROB_AGE_MAX_W-1:0] idx,
      input logic [ROB_AGE_MAX_W-1:0] head,
      input int unsigned              idx_w
   );
      logic [ROB_AGE_MAX_W-1:0] mask;
      mask = (ROB_AGE_MAX_W'(1) << idx_w) - ROB_AGE_MAX_W'(1);
      return (idx - head) & mask;
   endfunction

endpackage : branch_redirect_unit_pkg

// File: rtl/branch_redirect_unit.sv
// -----------------------------------------------------------------------------
// branch_redirect_unit
//
// Purpose : Tracks the oldest outstanding mispredicted control-flow instruction
//           reported by the branch unit (the front end always predicts
//           not-taken, so any taken branch / jump is a mispredict). When that
//           instruction retires, a one-cycle flush is issued together with a
//           fetch redirect that is held until fetch accepts it.
//
// Ports   :
//   clk              in   clock, all state on the rising edge
//   rst              in   asynchronous active-low reset
//   wb_valid         in   branch-unit result valid
//   wb_br_en         in   result needs a redirect (taken / jump)
//   wb_rob_idx       in   ROB entry of the result
//   wb_pc_new        in   corrected target PC
//   rob_head         in   index of the oldest ROB entry
//   commit_valid     in   an entry retires this cycle
//   commit_rob_idx   in   index of the retiring entry
//   redirect_ready   in   fetch accepts the redirect
//   flush            out  one-cycle squash pulse
//   redirect_valid   out  redirect request, held until accepted
//   redirect_pc      out  redirect target
//   busy             out  high while redirecting (dispatch stalls)
//   mispredict_count out  number of flushes issued (wraps)
// -----------------------------------------------------------------------------
module branch_redirect_unit
   import branch_redirect_unit_pkg::*;
#(
   parameter int ROB_IDX_W = ROB_IDX_W_DEF,
   parameter int XLEN      = XLEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_valid,
   input  logic                 wb_br_en,
   input  logic [ROB_IDX_W-1:0] wb_rob_idx,
   input  logic [XLEN-1:0]      wb_pc_new,
   input  logic [ROB_IDX_W-1:0] rob_head,
   input  logic                 commit_valid,
   input  logic [ROB_IDX_W-1:0] commit_rob_idx,
   input  logic                 redirect_ready,
   output logic                 flush,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   output logic                 busy,
   output logic [31:0]          mispredict_count
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   redirect_state_t        state_q,          state_d;
   logic [ROB_IDX_W-1:0]   pend_idx_q,       pend_idx_d;
   logic [XLEN-1:0]        pend_pc_q,        pend_pc_d;
   logic                   flush_q,          flush_d;
   logic                   redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]        redirect_pc_q,    redirect_pc_d;
   logic                   busy_q,           busy_d;
   logic [31:0]            count_q,          count_d;

   // ---------------------------------------------------------------------------
   // Decode of this cycle's writeback and commit
   // ---------------------------------------------------------------------------
   logic                     wb_mispredict;
   logic                     commit_hit;
   logic [ROB_AGE_MAX_W-1:0] wb_age;
   logic [ROB_AGE_MAX_W-1:0] pend_age;
   logic                     wb_older;

   assign wb_mispredict = wb_valid && wb_br_en;
   assign commit_hit    = commit_valid && (commit_rob_idx == pend_idx_q);

   assign wb_age   = rob_age(ROB_AGE_MAX_W'(wb_rob_idx), ROB_AGE_MAX_W'(rob_head),
                             ROB_IDX_W);
   assign pend_age = rob_age(ROB_AGE_MAX_W'(pend_idx_q), ROB_AGE_MAX_W'(rob_head),
                             ROB_IDX_W);
   // Strictly older only: a tie keeps the entry already held.
   assign wb_older = (wb_age < pend_age);

   // ---------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      pend_idx_d       = pend_idx_q;
      pend_pc_d        = pend_pc_q;
      flush_d          = 1'b0;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      busy_d           = busy_q;
      count_d          = count_q;

      unique case (state_q)
         IDLE: begin
            // Fall-through results (wb_br_en = 0) need no action.
            if (wb_mispredict) begin
               pend_idx_d = wb_rob_idx;
               pend_pc_d  = wb_pc_new;
               state_d    = PENDING;
            end
         end

         PENDING: begin
            if (commit_hit) begin
               // The held mispredict retires. Any writeback arriving in the
               // same cycle is younger and about to be squashed, so it is
               // dropped rather than compared.
               state_d          = REDIRECT;
               flush_d          = 1'b1;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = pend_pc_q;
               busy_d           = 1'b1;
               count_d          = count_q + 32'd1;
            end else if (wb_mispredict && wb_older) begin
               pend_idx_d = wb_rob_idx;
               pend_pc_d  = wb_pc_new;
            end
         end

         REDIRECT: begin
            // flush_d stays at its default of 0, so the pulse lasts exactly
            // one cycle however long fetch stalls. Writebacks are ignored:
            // everything in flight is being squashed.
            if (redirect_ready) begin
               state_d          = IDLE;
               redirect_valid_d = 1'b0;
               busy_d           = 1'b0;
            end
         end

         default: begin
            state_d          = IDLE;
            redirect_valid_d = 1'b0;
            busy_d           = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         pend_idx_q       <= '0;
         pend_pc_q        <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         busy_q           <= 1'b0;
         count_q          <= '0;
      end else begin
         state_q          <= state_d;
         pend_idx_q       <= pend_idx_d;
         pend_pc_q        <= pend_pc_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         busy_q           <= busy_d;
         count_q          <= count_d;
      end
   end

   assign flush            = flush_q;
   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign busy             = busy_q;
   assign mispredict_count = count_q;

endmodule : branch_redirect_unit

// File: tb/tb_branch_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_unit
//
// Directed-vector bench for branch_redirect_unit. Inputs change 1 ns after a
// rising edge; outputs are sampled at that same point, so they show the values
// registered on the edge just passed.
// -----------------------------------------------------------------------------
module tb_branch_redirect_unit;

   localparam int ROB_IDX_W = 4;
   localparam int XLEN      = 32;

   logic                 clk;
   logic                 rst;
   logic                 wb_valid;
   logic                 wb_br_en;
   logic [ROB_IDX_W-1:0] wb_rob_idx;
   logic [XLEN-1:0]      wb_pc_new;
   logic [ROB_IDX_W-1:0] rob_head;
   logic                 commit_valid;
   logic [ROB_IDX_W-1:0] commit_rob_idx;
   logic                 redirect_ready;
   logic                 flush;
   logic                 redirect_valid;
   logic [XLEN-1:0]      redirect_pc;
   logic                 busy;
   logic [31:0]          mispredict_count;

   int n_vec;
   int n_err;

   branch_redirect_unit #(
      .ROB_IDX_W (ROB_IDX_W),
      .XLEN      (XLEN)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .wb_valid         (wb_valid),
      .wb_br_en         (wb_br_en),
      .wb_rob_idx       (wb_rob_idx),
      .wb_pc_new        (wb_pc_new),
      .rob_head         (rob_head),
      .commit_valid     (commit_valid),
      .commit_rob_idx   (commit_rob_idx),
      .redirect_ready   (redirect_ready),
      .flush            (flush),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .busy             (busy),
      .mispredict_count (mispredict_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic br_en, input logic [3:0] idx, input logic [31:0] pc);
      wb_valid   = 1'b1;
      wb_br_en   = br_en;
      wb_rob_idx = idx;
      wb_pc_new  = pc;
   endtask

   task automatic wb_off();
      wb_valid   = 1'b0;
      wb_br_en   = 1'b0;
      wb_rob_idx = '0;
      wb_pc_new  = '0;
   endtask

   task automatic commit(input logic [3:0] idx);
      commit_valid   = 1'b1;
      commit_rob_idx = idx;
   endtask

   task automatic commit_off();
      commit_valid   = 1'b0;
      commit_rob_idx = '0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      wb_off();
      commit_off();
      rob_head       = '0;
      redirect_ready = 1'b0;

      // Reset state before any clock edge.
      #2;
      chk("rst_flush", 64'(flush), 64'd0);
      chk("rst_rv",    64'(redirect_valid), 64'd0);
      chk("rst_pc",    64'(redirect_pc), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_cnt",   64'(mispredict_count), 64'd0);
      #10 rst = 1'b1;
      step();

      // 1: basic mispredict, retire, immediate accept.
      rob_head = 4'd2;
      wb(1'b1, 4'd5, 32'h6000_0040);
      step();
      wb_off();
      commit(4'd5);
      redirect_ready = 1'b1;
      chk("t1_pre_flush", 64'(flush), 64'd0);
      step();
      commit_off();
      chk("t1_flush", 64'(flush), 64'd1);
      chk("t1_rv",    64'(redirect_valid), 64'd1);
      chk("t1_pc",    64'(redirect_pc), 64'h6000_0040);
      chk("t1_busy",  64'(busy), 64'd1);
      chk("t1_cnt",   64'(mispredict_count), 64'd1);
      step();
      chk("t1_post_flush", 64'(flush), 64'd0);
      chk("t1_post_rv",    64'(redirect_valid), 64'd0);
      chk("t1_post_busy",  64'(busy), 64'd0);

      // 2: fall-through result is ignored.
      wb(1'b0, 4'd3, 32'h0000_3000);
      step();
      wb_off();
      commit(4'd3);
      step();
      commit_off();
      chk("t2_flush", 64'(flush), 64'd0);
      chk("t2_rv",    64'(redirect_valid), 64'd0);
      step();
      chk("t2_cnt",   64'(mispredict_count), 64'd1);

      // 3: wrap-around age, older replacement (idx 15 age 1 beats idx 1 age 3).
      rob_head = 4'd14;
      wb(1'b1, 4'd1, 32'h0000_0100);
      step();
      wb(1'b1, 4'd15, 32'h0000_0200);
      step();
      wb_off();
      commit(4'd15);
      step();
      commit_off();
      chk("t3_flush", 64'(flush), 64'd1);
      chk("t3_pc",    64'(redirect_pc), 64'h0000_0200);
      step();
      commit(4'd1);
      step();
      commit_off();
      chk("t3_stale_flush", 64'(flush), 64'd0);
      chk("t3_stale_rv",    64'(redirect_valid), 64'd0);
      chk("t3_cnt",         64'(mispredict_count), 64'd2);

      // 4: equal age keeps the held entry; redirect_ready held low 3 cycles
      //    with writeback mispredicts arriving throughout.
      rob_head       = 4'd0;
      redirect_ready = 1'b0;
      wb(1'b1, 4'd6, 32'h0000_0A00);
      step();
      wb(1'b1, 4'd6, 32'h0000_0B00);
      step();
      wb_off();
      commit(4'd6);
      step();
      commit_off();
      chk("t4_c1_flush", 64'(flush), 64'd1);
      chk("t4_c1_pc",    64'(redirect_pc), 64'h0000_0A00);
      chk("t4_cnt",      64'(mispredict_count), 64'd3);
      for (int k = 2; k <= 4; k++) begin
         wb(1'b1, 4'd0, 32'h0000_0C00);
         step();
         chk($sformatf("t4_c%0d_flush", k), 64'(flush), 64'd0);
         chk($sformatf("t4_c%0d_rv", k),    64'(redirect_valid), 64'd1);
         chk($sformatf("t4_c%0d_pc", k),    64'(redirect_pc), 64'h0000_0A00);
         chk($sformatf("t4_c%0d_busy", k),  64'(busy), 64'd1);
      end
      wb_off();
      redirect_ready = 1'b1;
      step();
      chk("t4_done_rv",   64'(redirect_valid), 64'd0);
      chk("t4_done_busy", 64'(busy), 64'd0);
      commit(4'd0);
      step();
      commit_off();
      chk("t4_nocap_flush", 64'(flush), 64'd0);
      chk("t4_cnt_after",   64'(mispredict_count), 64'd3);

      // 5: commit of pending idx 4 coincides with a mispredict at idx 7.
      wb(1'b1, 4'd4, 32'h0000_0400);
      step();
      wb(1'b1, 4'd7, 32'h0000_0700);
      commit(4'd4);
      step();
      wb_off();
      commit_off();
      chk("t5_flush", 64'(flush), 64'd1);
      chk("t5_pc",    64'(redirect_pc), 64'h0000_0400);
      chk("t5_cnt",   64'(mispredict_count), 64'd4);
      step();
      chk("t5_idle_rv", 64'(redirect_valid), 64'd0);
      commit(4'd7);
      step();
      commit_off();
      chk("t5_drop_flush", 64'(flush), 64'd0);
      chk("t5_drop_rv",    64'(redirect_valid), 64'd0);

      // 6: asynchronous reset in the middle of REDIRECT.
      redirect_ready = 1'b0;
      wb(1'b1, 4'd9, 32'h0000_0900);
      step();
      wb_off();
      commit(4'd9);
      step();
      commit_off();
      chk("t6_in_redirect", 64'(redirect_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_flush", 64'(flush), 64'd0);
      chk("t6_rst_rv",    64'(redirect_valid), 64'd0);
      chk("t6_rst_pc",    64'(redirect_pc), 64'd0);
      chk("t6_rst_busy",  64'(busy), 64'd0);
      chk("t6_rst_cnt",   64'(mispredict_count), 64'd0);
      #10 rst = 1'b1;
      step();
      redirect_ready = 1'b1;
      wb(1'b1, 4'd3, 32'h0000_1234);
      step();
      wb_off();
      commit(4'd3);
      step();
      commit_off();
      chk("t6_new_flush", 64'(flush), 64'd1);
      chk("t6_new_pc",    64'(redirect_pc), 64'h0000_1234);
      chk("t6_new_cnt",   64'(mispredict_count), 64'd1);
      step();
      chk("t6_new_idle", 64'(redirect_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_branch_redirect_unit
